// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file.
// Holds the CLEAR/RUN state encoding and the default parameter values
// used by regfile_mp and its clear sequencer.
package regfile_pkg;

  // Default geometry of the register file.
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEF_NUM_RD = 2;

  // CLEAR: array is being zeroed after reset; RUN: normal operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

endpackage : regfile_pkg

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer for regfile_mp.
// Walks clear_ptr over every entry (one per cycle) while in CLEAR, then
// moves to RUN and raises ready, which stays high until the next reset.
// Ports:
//   clk        - clock, rising edge
//   reset      - synchronous, active-low reset
//   clr_we_o   - high while the sequencer owns the array write port
//   clr_addr_o - entry being zeroed this cycle
//   ready_o    - registered; high once every entry has been zeroed
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              ready_o
);

  // Last entry of the array: DEPTH-1 is all ones.
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clear_ptr_q, clear_ptr_d;
  logic              ready_q, ready_d;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= CLEAR;
      clear_ptr_q <= '0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      ready_q     <= ready_d;
    end
  end

  // Next-state logic: advance the pointer each CLEAR cycle, leave after
  // the last entry has been written.
  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    ready_d     = ready_q;
    if (state_q == CLEAR) begin
      clear_ptr_d = clear_ptr_q + ADDR_W'(1);
      if (clear_ptr_q == LAST_ADDR) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end
  end

  // Decoded straight from registers, so no input-to-output path.
  assign clr_we_o   = (state_q == CLEAR);
  assign clr_addr_o = clear_ptr_q;
  assign ready_o    = ready_q;

endmodule : regfile_clear_seq

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD registered read ports,
// one byte-masked write port, same-cycle write-to-read bypass and an
// optional hardwired-zero entry 0. After reset the array is zeroed by a
// clear sequencer; ready rises once every entry is known zero.
// Ports:
//   clk      - clock, rising edge
//   reset    - synchronous, active-low reset
//   rd_en    - per-port read enable
//   rd_addr  - read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data  - registered read data, port i at [i*DATA_W +: DATA_W]
//   wr_en    - write enable
//   wr_addr  - write address
//   wr_be    - byte enables, bit b covers wr_data[8b +: 8]
//   wr_data  - write data
//   ready    - high once the clear sequence has completed
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned NUM_RD  = DEF_NUM_RD,
  parameter int unsigned ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned NB    = DATA_W / 8;

  // Storage array; intentionally not reset, the clear sequencer zeroes it.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              in_clear;
  logic [ADDR_W-1:0] clr_addr;

  regfile_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .reset      (reset),
    .clr_we_o   (in_clear),
    .clr_addr_o (clr_addr),
    .ready_o    (ready)
  );

  // External write qualified: dropped during CLEAR and to entry 0 when
  // entry 0 is hardwired. Shared by the array write and the bypass.
  logic wr_r0_c;
  logic ext_wr_c;
  assign wr_r0_c  = (ZERO_R0 != 0) && (wr_addr == '0);
  assign ext_wr_c = !in_clear && wr_en && !wr_r0_c;

  // Byte merge of the incoming data over the currently stored word.
  logic [DATA_W-1:0] old_word_c;
  logic [DATA_W-1:0] merged_c;
  assign old_word_c = mem_q[wr_addr];

  for (genvar b = 0; b < NB; b++) begin : g_merge
    assign merged_c[8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : old_word_c[8*b +: 8];
  end

  // Array write port mux: clear sequencer has priority; nothing is
  // written on a reset edge.
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = wr_addr;
    mem_wdata_c = merged_c;
    if (in_clear) begin
      mem_we_c    = reset;
      mem_addr_c  = clr_addr;
      mem_wdata_c = '0;
    end else begin
      mem_we_c = reset && ext_wr_c && (wr_be != '0);
    end
  end

  // Array write.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_addr_c] <= mem_wdata_c;
    end
  end

  // Read ports: registered, hold when not enabled, bypass on address hit.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_c;
    logic              hit_c;
    logic [DATA_W-1:0] rd_d;
    logic [DATA_W-1:0] rd_q;

    assign ra_c  = rd_addr[i*ADDR_W +: ADDR_W];
    assign hit_c = ext_wr_c && (wr_addr == ra_c);

    always_comb begin
      rd_d = rd_q;
      if (in_clear) begin
        rd_d = '0;
      end else if (rd_en[i]) begin
        if ((ZERO_R0 != 0) && (ra_c == '0)) begin
          rd_d = '0;
        end else if (hit_c) begin
          rd_d = merged_c;
        end else begin
          rd_d = mem_q[ra_c];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_d;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rd_q;
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Scoreboard testbench for regfile_mp. Two instances share stimulus:
// one with a hardwired-zero entry 0 and one without. A reference model
// predicts ready and every read lane per cycle and queues the result;
// a monitor pops and compares after each rising edge.
module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [3:0]       wr_be;
  logic [DW-1:0]    wr_data;
  logic [NR*DW-1:0] rd_data_z, rd_data_n;
  logic             ready_z, ready_n;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(1)) u_dut_z (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_z),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .ready(ready_z)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_R0(0)) u_dut_n (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data), .ready(ready_n)
  );

  typedef struct packed {
    logic             rdy;
    logic [NR*DW-1:0] lz;
    logic [NR*DW-1:0] ln;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] mz [DEPTH];
  logic [31:0] mn [DEPTH];
  logic [31:0] lane_z [NR];
  logic [31:0] lane_n [NR];
  int          post_rst_edges;
  int          total;
  int          bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus and predict the state after the next edge.
  task automatic cyc(input logic rst_v, input logic [NR-1:0] ren,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic we, input logic [AW-1:0] wa,
                     input logic [3:0] be, input logic [31:0] wd);
    exp_t        e;
    logic [AW-1:0] ra [NR];
    @(negedge clk);
    reset   = rst_v;
    rd_en   = ren;
    rd_addr = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_be   = be;
    wr_data = wd;
    ra[0] = a0;
    ra[1] = a1;
    if (!rst_v) begin
      post_rst_edges = 0;
      for (int i = 0; i < NR; i++) begin
        lane_z[i] = '0;
        lane_n[i] = '0;
      end
    end else if (post_rst_edges < DEPTH) begin
      // k-th edge after release zeroes entry k; reads and writes ignored
      mz[post_rst_edges] = '0;
      mn[post_rst_edges] = '0;
      post_rst_edges++;
      for (int i = 0; i < NR; i++) begin
        lane_z[i] = '0;
        lane_n[i] = '0;
      end
    end else begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) begin
            mn[wa][8*b +: 8] = wd[8*b +: 8];
            if (wa != 0) mz[wa][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
      // read after write gives the bypass result
      for (int i = 0; i < NR; i++) begin
        if (ren[i]) begin
          lane_z[i] = mz[ra[i]];
          lane_n[i] = mn[ra[i]];
        end
      end
    end
    e.rdy = rst_v && (post_rst_edges >= DEPTH);
    e.lz  = {lane_z[1], lane_z[0]};
    e.ln  = {lane_n[1], lane_n[0]};
    exp_q.push_back(e);
  endtask

  task automatic rnd_cyc(input logic rst_v);
    logic [AW-1:0] a0, a1, wa;
    a0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
    a1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
    wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom);
    cyc(rst_v, NR'($urandom), a0, a1, 1'($urandom), wa, 4'($urandom), $urandom);
  endtask

  // Monitor: compare every predicted cycle just after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("ready_z", 32'(ready_z), 32'(mon_e.rdy));
        chk("ready_n", 32'(ready_n), 32'(mon_e.rdy));
        for (int i = 0; i < NR; i++) begin
          chk($sformatf("lane%0d_zero_r0", i), rd_data_z[i*DW +: DW], mon_e.lz[i*DW +: DW]);
          chk($sformatf("lane%0d_plain", i), rd_data_n[i*DW +: DW], mon_e.ln[i*DW +: DW]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    post_rst_edges = 0;
    reset   = 1'b0;
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    wr_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      mz[k] = $urandom;
      mn[k] = $urandom;
    end
    for (int i = 0; i < NR; i++) begin
      lane_z[i] = '0;
      lane_n[i] = '0;
    end

    // Reset, then 10 clear cycles with a dropped write and ignored reads.
    cyc(1'b0, 2'b00, 0, 0, 1'b0, 0, 4'h0, 0);
    cyc(1'b0, 2'b00, 0, 0, 1'b0, 0, 4'h0, 0);
    for (int k = 0; k < 10; k++)
      cyc(1'b1, 2'b11, AW'(k), 5'd3, k == 5, 5'd3, 4'hF, 32'h1234_5678);

    // Reset mid-CLEAR restarts the full sequence.
    cyc(1'b0, 2'b00, 0, 0, 1'b0, 0, 4'h0, 0);
    for (int k = 0; k < 34; k++)
      cyc(1'b1, 2'b11, 5'd3, AW'(k), k == 5, 5'd3, 4'hF, 32'h1234_5678);

    // Every entry reads zero after the clear.
    for (int k = 0; k < DEPTH; k++)
      cyc(1'b1, 2'b11, AW'(k), AW'(DEPTH - 1 - k), 1'b0, 0, 4'h0, 0);

    // Full write then read on the next edge.
    cyc(1'b1, 2'b00, 0, 0, 1'b1, 5'd5, 4'hF, 32'hDEAD_BEEF);
    cyc(1'b1, 2'b11, 5'd5, 5'd6, 1'b0, 0, 4'h0, 0);

    // Same-edge byte-masked bypass on both ports.
    cyc(1'b1, 2'b00, 0, 0, 1'b1, 5'd7, 4'hF, 32'h1122_3344);
    cyc(1'b1, 2'b11, 5'd7, 5'd7, 1'b1, 5'd7, 4'b0101, 32'hAABB_CCDD);
    cyc(1'b1, 2'b11, 5'd7, 5'd7, 1'b0, 0, 4'h0, 0);

    // Entry 0: hardwired on one instance, ordinary on the other.
    cyc(1'b1, 2'b11, 5'd0, 5'd0, 1'b1, 5'd0, 4'hF, 32'hFFFF_FFFF);
    cyc(1'b1, 2'b11, 5'd0, 5'd0, 1'b0, 0, 4'h0, 0);

    // wr_be=0 is a no-op; lanes hold while rd_en=0.
    cyc(1'b1, 2'b11, 5'd5, 5'd7, 1'b1, 5'd5, 4'h0, 32'h0BAD_0BAD);
    for (int k = 0; k < 4; k++)
      cyc(1'b1, 2'b00, 5'd1, 5'd2, 1'b1, 5'd5, 4'hF, $urandom);
    cyc(1'b1, 2'b01, 5'd5, 5'd7, 1'b0, 0, 4'h0, 0);

    // Random traffic, then a reset from RUN and more traffic.
    for (int k = 0; k < 400; k++) rnd_cyc(1'b1);
    cyc(1'b0, 2'b11, 0, 0, 1'b1, 5'd4, 4'hF, 32'h5555_AAAA);
    for (int k = 0; k < 120; k++) rnd_cyc(1'b1);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the RISC CPU datapath: NUM_RD registered read ports and one byte-masked write port. Same-cycle write-to-read bypass and an optional hardwired-zero register 0. After reset, a clear sequencer zeroes every entry one per cycle, and `ready` is asserted only when the whole array is known-zero. This removes any dependence on a preload file. The block sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_R0, 1, when 1, entry 0 always reads 0 and writes to it are discarded

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- reset  input  1  synchronous, active-low reset
- rd_en  input  NUM_RD  per-port read enable
- rd_addr  input  NUM_RD*ADDR_W  port i occupies bits [i*ADDR_W +: ADDR_W]
- rd_data  output  NUM_RD*DATA_W  registered read data; port i occupies bits [i*DATA_W +: DATA_W]
- wr_en  input  1  write enable
- wr_addr  input  ADDR_W  write address
- wr_be  input  DATA_W/8  byte enables; bit b covers data bits [8b +: 8]
- wr_data  input  DATA_W  write data
- ready  output  1  high once the clear sequence has completed

## Operation
- State machine states: CLEAR and RUN.
- Reset (reset=0 at a rising edge):
  - state goes to CLEAR and clear_ptr goes to 0
  - ready goes to 0 and every rd_data lane goes to 0
  - array contents are not touched
- CLEAR:
  - each edge with reset=1 writes 0 to entry clear_ptr, then increments clear_ptr
  - at the edge that writes entry DEPTH-1, state goes to RUN and ready goes to 1
  - in this state wr_en is ignored (the write is dropped, not deferred), rd_en is ignored, and rd_data is held at 0
- Reset asserted mid-CLEAR restarts the sequence at entry 0.
- RUN write: when wr_en=1, only the byte lanes with wr_be[b]=1 are updated; the other bytes keep their old value.
  - wr_be=0 is a no-op
  - with ZERO_R0=1, a write to address 0 is discarded
- RUN read: when rd_en[i]=1, rd_data lane i loads the entry at rd_addr[i]; when rd_en[i]=0, the lane holds its previous value.
- Bypass: if wr_en=1 and wr_addr equals rd_addr[i] at the same edge, lane i loads the byte-merged value:
  - new bytes where wr_be=1
  - old bytes elsewhere
  - bypass is suppressed for address 0 when ZERO_R0=1
- Any number of read ports may address the same entry; each behaves independently.
- No write-write conflict is possible (single write port).

## Timing
- Read latency is 1 cycle: address sampled at edge N, data visible after edge N, usable in cycle N+1.
- Write latency is 1 cycle: data written at edge N is returned by a read sampled at edge N (via bypass) or at any later edge.
- Clear duration is DEPTH edges after reset deassertion; ready=1 from the cycle after the DEPTH-th such edge (32 cycles at default parameters).
- ready is registered and never returns to 0 except by reset.
- No combinational path from any input to any output.

## Structure
- Shared package regfile_pkg holds:
  - the state encoding (CLEAR=1'b0, RUN=1'b1)
  - default parameter constants: DATA_W, ADDR_W, NUM_RD
- Sub-module regfile_clear_seq contains:
  - the CLEAR/RUN state register
  - clear_ptr (ADDR_W bits) and ready
  - outputs: clear write enable and clear address
- The top level muxes between the clear sequencer and the external write port, and holds the array, the byte merge, the bypass comparators and the read registers (generate loop over NUM_RD).

## Test plan
- Reset for 2 cycles, release, poll ready -> ready=0 for exactly 32 cycles, then 1; reads of all 32 entries return 0x00000000.
- After ready: write 0xDEADBEEF to r5 with wr_be=4'hF, read r5 on port 0 at the next edge -> 0xDEADBEEF one cycle later; port 1 on r6 -> 0.
- Same-edge bypass: r7 holds 0x11223344; write 0xAABBCCDD with wr_be=4'b0101 while both ports read r7 -> both lanes show 0x11BB33DD; a later read gives the same value.
- ZERO_R0=1: write 0xFFFFFFFF to r0 while reading r0 -> 0; a later read -> 0. Repeat with ZERO_R0=0 -> 0xFFFFFFFF.
- Writes during CLEAR: issue wr_en to r3 with 0x12345678 at cycle 5 after release -> after ready, r3 reads 0.
- Reset mid-CLEAR: assert reset at cycle 10 of the clear sequence, release -> ready reasserts after a full 32 further cycles; rd_en=0 holds lane values across RUN cycles.
